// File: rtl/seg_bcd_conv_if.sv
// seg_bcd_conv bus: start/data request in, busy/valid and display digits out.
// master = requester (ALU side), slave = converter.
interface seg_bcd_conv_if #(
   parameter int DATA_W = 26
);
   logic              i_start;
   logic              i_signed;
   logic [DATA_W-1:0] i_data;
   logic              o_busy;
   logic              o_valid;
   logic [31:0]       o_bcd;
   logic              o_neg;
   logic [7:0]        o_blank;

   modport master (
      output i_start,
      output i_signed,
      output i_data,
      input  o_busy,
      input  o_valid,
      input  o_bcd,
      input  o_neg,
      input  o_blank
   );

   modport slave (
      input  i_start,
      input  i_signed,
      input  i_data,
      output o_busy,
      output o_valid,
      output o_bcd,
      output o_neg,
      output o_blank
   );
endinterface

// File: rtl/seg_bcd_conv.sv
// seg_bcd_conv: sequential double-dabble binary-to-BCD, one shift per clock.
// Ports: clk, rst (async, active low), bus (slave: start/signed/data in; busy/valid/bcd/neg/blank out).
module seg_bcd_conv #(
   parameter int DATA_W = 26,
   parameter int CNT_W  = 5
) (
   input  logic          clk,
   input  logic          rst,
   seg_bcd_conv_if.slave bus
);

   generate
      if (DATA_W < 4 || DATA_W > 26 || (1 << CNT_W) <= DATA_W) begin : g_bad_param
         $error("seg_bcd_conv: illegal DATA_W/CNT_W");
      end
   endgenerate

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t            state;
   state_t            state_d;

   logic [DATA_W-1:0] mag;
   logic [31:0]       acc;
   logic [CNT_W-1:0]  cnt;
   logic              neg_q;

   logic              valid_q;
   logic [31:0]       bcd_q;
   logic              neg_out_q;
   logic [7:0]        blank_q;

   logic [31:0]       acc_adj;
   logic [31:0]       acc_sh;
   logic [DATA_W-1:0] mag_in;
   logic              neg_in;
   logic              last;
   logic [7:0]        blank_d;

   // Two's-complement magnitude; the most negative value maps onto
   // 2^(DATA_W-1), which still fits as an unsigned DATA_W-bit number.
   always_comb begin
      neg_in = bus.i_signed & bus.i_data[DATA_W-1];
      mag_in = bus.i_data;
      if (neg_in) begin
         mag_in = ~bus.i_data + DATA_W'(1);
      end
   end

   // Digit correction before each shift keeps every nibble a legal
   // decimal digit after doubling.
   always_comb begin
      acc_adj = acc;
      for (int k = 0; k < 8; k++) begin
         if (acc[4*k +: 4] >= 4'd5) begin
            acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
         end
      end
   end

   assign acc_sh = {acc_adj[30:0], mag[DATA_W-1]};
   assign last   = (cnt == CNT_W'(DATA_W - 1));

   // Digit i is blanked only when it and every digit above it are zero.
   always_comb begin
      blank_d = 8'h00;
      for (int i = 1; i < 8; i++) begin
         blank_d[i] = ((acc_sh >> (4 * i)) == 32'd0);
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE: begin
            if (bus.i_start) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mag       <= '0;
         acc       <= '0;
         cnt       <= '0;
         neg_q     <= 1'b0;
         valid_q   <= 1'b0;
         bcd_q     <= '0;
         neg_out_q <= 1'b0;
         blank_q   <= 8'hFE;
      end else begin
         valid_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.i_start) begin
                  mag   <= mag_in;
                  neg_q <= neg_in;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               acc <= acc_sh;
               mag <= {mag[DATA_W-2:0], 1'b0};
               cnt <= cnt + CNT_W'(1);
               if (last) begin
                  bcd_q     <= acc_sh;
                  neg_out_q <= neg_q;
                  blank_q   <= blank_d;
                  valid_q   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_busy  = (state == SHIFT);
   assign bus.o_valid = valid_q;
   assign bus.o_bcd   = bcd_q;
   assign bus.o_neg   = neg_out_q;
   assign bus.o_blank = blank_q;

endmodule

// File: tb/tb_seg_bcd_conv.sv
// tb_seg_bcd_conv: directed + random checks of seg_bcd_conv against
// an arithmetic decimal model.
module tb_seg_bcd_conv;

   localparam int DATA_W = 26;
   localparam int CNT_W  = 5;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   seg_bcd_conv_if #(.DATA_W(DATA_W)) bus ();

   seg_bcd_conv #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits of the magnitude by repeated division.
   function automatic void model(input logic sg, input logic [DATA_W-1:0] d,
                                 output logic [31:0] bcd, output logic neg,
                                 output logic [7:0] blank);
      longint v;
      longint p;
      neg = sg && d[DATA_W-1];
      v   = neg ? ((64'd1 << DATA_W) - longint'(d)) : longint'(d);
      p   = 1;
      blank = 8'h00;
      for (int i = 1; i < 8; i++) begin
         p = p * 10;
         blank[i] = (v < p);
      end
      for (int k = 0; k < 8; k++) begin
         bcd[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
   endfunction

   // Called at a negedge; returns at the negedge after the start edge.
   task automatic start_conv(input logic sg, input logic [DATA_W-1:0] d);
      bus.i_start  = 1'b1;
      bus.i_signed = sg;
      bus.i_data   = d;
      @(negedge clk);
      bus.i_start  = 1'b0;
      bus.i_signed = $urandom_range(0, 1);
      bus.i_data   = DATA_W'($urandom);
   endtask

   // edges = rising edges since the start edge when o_valid is seen.
   task automatic wait_valid(input int e0, output int edges);
      edges = e0;
      while (bus.o_valid !== 1'b1 && edges < 100) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic check_out(input string tag, input logic sg, input logic [DATA_W-1:0] d);
      logic [31:0] eb;
      logic        en;
      logic [7:0]  ebl;
      model(sg, d, eb, en, ebl);
      chk({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
      chk({tag, ".bcd"},   bus.o_bcd, eb);
      chk({tag, ".neg"},   32'(bus.o_neg), 32'(en));
      chk({tag, ".blank"}, 32'(bus.o_blank), 32'(ebl));
      chk({tag, ".busy"},  32'(bus.o_busy), 32'd0);
   endtask

   task automatic conv(input string tag, input logic sg, input logic [DATA_W-1:0] d);
      int e;
      start_conv(sg, d);
      chk({tag, ".busy_run"}, 32'(bus.o_busy), 32'd1);
      wait_valid(0, e);
      chk({tag, ".latency"}, 32'(e), 32'(DATA_W));
      check_out(tag, sg, d);
   endtask

   int e;
   int nval;
   logic [DATA_W-1:0] rd;
   logic rs;

   initial begin
      compared     = 0;
      mismatched   = 0;
      rst          = 1'b0;
      bus.i_start  = 1'b0;
      bus.i_signed = 1'b0;
      bus.i_data   = '0;
      repeat (3) @(negedge clk);
      chk("rst.busy",  32'(bus.o_busy), 32'd0);
      chk("rst.valid", 32'(bus.o_valid), 32'd0);
      chk("rst.bcd",   bus.o_bcd, 32'h0);
      chk("rst.neg",   32'(bus.o_neg), 32'd0);
      chk("rst.blank", 32'(bus.o_blank), 32'hFE);
      rst = 1'b1;
      @(negedge clk);

      conv("zero", 1'b0, '0);
      chk("zero.lit", bus.o_bcd, 32'h00000000);

      conv("u12345678", 1'b0, DATA_W'(12345678));
      chk("u12345678.lit", bus.o_bcd, 32'h12345678);
      conv("b2b905", 1'b0, DATA_W'(905));
      chk("b2b905.lit", 32'(bus.o_blank), 32'hF8);
      @(negedge clk);
      chk("pulse_len", 32'(bus.o_valid), 32'd0);

      conv("s_ones", 1'b1, {DATA_W{1'b1}});
      chk("s_ones.lit", bus.o_bcd, 32'h00000001);
      conv("s_min", 1'b1, DATA_W'(26'h2000000));
      chk("s_min.lit", bus.o_bcd, 32'h33554432);
      conv("u_msb", 1'b0, DATA_W'(26'h2000000));

      // Extra start mid-conversion must be dropped.
      start_conv(1'b0, {DATA_W{1'b1}});
      repeat (4) @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_data  = DATA_W'(123);
      @(negedge clk);
      bus.i_start = 1'b0;
      wait_valid(5, e);
      chk("ign.latency", 32'(e), 32'(DATA_W));
      check_out("ign", 1'b0, {DATA_W{1'b1}});
      chk("ign.lit", bus.o_bcd, 32'h67108863);
      nval = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.o_valid === 1'b1) nval++;
      end
      chk("ign.extra_valid", 32'(nval), 32'd0);

      // Asynchronous reset mid-cycle during shift 10.
      start_conv(1'b0, DATA_W'(4321));
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst.busy",  32'(bus.o_busy), 32'd0);
      chk("arst.valid", 32'(bus.o_valid), 32'd0);
      chk("arst.bcd",   bus.o_bcd, 32'h0);
      chk("arst.neg",   32'(bus.o_neg), 32'd0);
      chk("arst.blank", 32'(bus.o_blank), 32'hFE);
      @(negedge clk);
      rst = 1'b1;
      nval = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.o_valid === 1'b1) nval++;
      end
      chk("arst.no_valid", 32'(nval), 32'd0);
      conv("after_rst7", 1'b0, DATA_W'(7));
      chk("after_rst7.lit", bus.o_bcd, 32'h00000007);
      @(negedge clk);

      // Held result must not move while the next conversion runs.
      start_conv(1'b0, DATA_W'(99));
      e = 0;
      while (bus.o_valid !== 1'b1 && e < 100) begin
         chk("hold.bcd", bus.o_bcd, 32'h00000007);
         @(negedge clk);
         e++;
      end
      chk("hold.latency", 32'(e), 32'(DATA_W));
      chk("hold.new", bus.o_bcd, 32'h00000099);

      for (int n = 0; n < 24; n++) begin
         rs = 1'($urandom_range(0, 1));
         rd = DATA_W'($urandom);
         if (n % 6 == 0) rd = rd >> $urandom_range(0, DATA_W - 1);
         conv("rand", rs, rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seg_bcd_conv.md
Name: seg_bcd_conv

Overview:
- Sequential binary-to-BCD converter, upstream of the 7-segment display driver; converts an ALU result into eight BCD digits, one per display position.
- Uses the double-dabble algorithm: one shift per clock, so a few hundred LUTs are not spent on a combinational divider.
- Optional signed input: produces the magnitude digits plus a sign flag.
- Also produces a leading-zero blanking mask for the display stage.

Parameters:
- DATA_W, 26, input width in bits. Legal range 4..26, so the maximum unsigned value 67,108,863 fits in 8 digits.
- CNT_W, 5, shift-counter width. Must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous reset, active low (rst=0 resets).
- i_start  input  1  request a conversion; sampled only when o_busy=0.
- i_signed  input  1  1: treat i_data as two's complement; sampled with i_start.
- i_data  input  DATA_W  value to convert; sampled with i_start.
- o_busy  output  1  conversion in progress; i_start is ignored while high.
- o_valid  output  1  one-cycle pulse; o_bcd, o_neg and o_blank have just been updated.
- o_bcd  output  32  8 BCD nibbles; [3:0] is the least significant digit (digit 0), [31:28] is digit 7.
- o_neg  output  1  1 if the input was signed and negative.
- o_blank  output  8  bit i=1 if digit i is a leading zero. Bit 0 is always 0.

Behaviour:
- Reset (rst=0, async): state=IDLE, o_busy=0, o_valid=0, o_bcd=0, o_neg=0, o_blank=8'hFE. Internal shift and BCD registers and counter are cleared.
- Reset during SHIFT aborts the conversion. No o_valid is produced, and outputs take their reset values.
- States: IDLE, SHIFT.
- IDLE, on an edge with i_start=1:
  - Capture mag = (i_signed && i_data[DATA_W-1]) ? -i_data : i_data, computed in DATA_W bits.
  - Capture neg = i_signed & i_data[DATA_W-1].
  - Clear the BCD accumulator, set cnt=0, go to SHIFT, o_busy=1.
  - The most negative signed value has magnitude 2^(DATA_W-1), which fits unsigned in DATA_W bits.
- SHIFT, each edge:
  - Add 3 to every accumulator nibble that is >=5.
  - Shift {acc, mag} left by 1, then cnt<=cnt+1.
- On the edge where cnt==DATA_W-1 (the DATA_W-th shift):
  - Load o_bcd with the final accumulator value and o_neg with neg.
  - Load o_blank: bit i=1 if and only if nibbles i..7 are all zero, for i=1..7. Bit 0 is 0.
  - Set o_valid=1 for exactly one cycle, o_busy=0, state=IDLE.
- Latency: o_valid is high in the cycle following the DATA_W-th edge after the start edge.
- o_bcd, o_neg and o_blank hold their values until the next completion or reset. They do not change during a conversion.
- i_start while o_busy=1 is ignored and not queued. i_data and i_signed are don't-care while busy.
- i_start in the o_valid cycle is accepted, since o_busy=0 in that cycle. This gives back-to-back conversions with throughput of one per DATA_W+1 cycles.
- o_valid is a pulse, not a handshake. The consumer latches the outputs or simply uses the held values.
- i_signed=0 with i_data MSB=1: treated as an unsigned value, and o_neg=0.

Test Plan:
- Reset, then start with i_data=0, unsigned -> o_valid exactly DATA_W edges after the start edge; o_bcd=32'h00000000, o_blank=8'hFE, o_neg=0.
- i_data=12345678 unsigned -> o_bcd=32'h12345678, o_blank=8'h00. A second start in the o_valid cycle with i_data=905 -> o_bcd=32'h00000905, o_blank=8'hF8.
- Signed inputs:
  - i_data=all ones -> o_bcd=32'h00000001, o_neg=1, o_blank=8'hFE.
  - i_data=26'h2000000 -> o_bcd=32'h33554432, o_neg=1.
- Unsigned i_data=26'h3FFFFFF -> o_bcd=32'h67108863, o_neg=0. Pulse i_start again at cycle 5 of the conversion -> ignored: exactly one o_valid, and the result is unchanged.
- Start a conversion of 4321 and assert rst=0 asynchronously mid-cycle at shift 10 -> outputs immediately take reset values, with no o_valid. After release, a new start of 7 -> o_bcd=32'h00000007.
- Between completions, o_bcd stays stable while a new conversion of 99 runs, then switches to 32'h00000099 on the o_valid cycle.
